// File: rtl/spi_bus_regs_pkg.sv
// spi_bus_regs_pkg
// Purpose: shared constants and types for the SPI-visible register block.
//   Holds the register address map, control-register bit positions, the
//   byte returned on a stream underrun and the bus-side FSM state type.
// Ports: none (package).
package spi_bus_regs_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_MSB = 6;

  // Register address map
  localparam logic [ADDR_MSB:0] REG_STATUS   = 7'h00;
  localparam logic [ADDR_MSB:0] REG_CTRL     = 7'h01;
  localparam logic [ADDR_MSB:0] REG_STREAM   = 7'h02;
  localparam logic [ADDR_MSB:0] REG_COUNT    = 7'h03;
  localparam logic [ADDR_MSB:0] REG_SCRATCH0 = 7'h04;

  // Control register bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  // Byte handed back when a stream read gives up waiting for data
  localparam logic [DATA_W-1:0] UNDERRUN_FILL = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/spi_bus_regs_if.sv
// spi_bus_regs_if
// Purpose: classic single-transfer bus between the SPI slave bus master and
//   the register block.
// Signals:
//   cyc  - bus cycle active            stb  - transfer strobe
//   we   - 1 = write, 0 = read         adr  - register address
//   datW - write data (master->slave)  datR - read data, valid while ack
//   ack  - single-cycle acknowledge
// Modports: master (drives request), slave (drives datR/ack).
interface spi_bus_regs_if #(
  parameter int WIDTH = 8,
  parameter int ASB   = 6
);

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ASB:0]     adr;
  logic [WIDTH-1:0] datW;
  logic [WIDTH-1:0] datR;
  logic             ack;

  modport master (output cyc, stb, we, adr, datW, input datR, ack);
  modport slave  (input cyc, stb, we, adr, datW, output datR, ack);

endinterface

// File: rtl/spi_bus_regs.sv
// spi_bus_regs
// Purpose: bus slave providing the SPI register map (status, control, byte
//   counter, four scratch bytes) and a streaming read port that pops bytes
//   from an upstream valid/ready source. A stream read that finds no data
//   waits at most TIMEOUT cycles, then is acked with a fill byte and the
//   sticky underrun flag is raised.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   bus            - slave side of spi_bus_regs_if (cyc/stb/we/adr/dat/ack)
//   src_dat_i      - stream byte           src_vld_i - stream byte available
//   src_rdy_o      - combinational pop strobe
//   ctrl_o         - control register      underrun_o - sticky underrun flag
module spi_bus_regs
  import spi_bus_regs_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               ASB       = 6,
  parameter int               TIMEOUT   = 15,
  parameter logic [WIDTH-1:0] CTRL_INIT = 8'h01
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  spi_bus_regs_if.slave        bus,
  input  logic [WIDTH-1:0]     src_dat_i,
  input  logic                 src_vld_i,
  output logic                 src_rdy_o,
  output logic [WIDTH-1:0]     ctrl_o,
  output logic                 underrun_o
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic             underrun_q, underrun_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] scratch_q [4];
  logic [WIDTH-1:0] scratch_d [4];

  logic             hit;
  logic             streamRd;
  logic             isScratch;
  logic             pop;
  logic [WIDTH-1:0] rdMux;

  // A transfer is only accepted while no ack is outstanding, so the master
  // holding stb through its ack cycle cannot start a second transfer.
  assign hit       = bus.cyc && bus.stb && !ack_q;
  assign streamRd  = (bus.adr == REG_STREAM) && !bus.we;
  assign isScratch = (bus.adr[ASB:2] == REG_SCRATCH0[ASB:2]);

  // Read data for every non-popping address; a disabled stream and
  // unmapped addresses fall through to zero.
  always_comb begin
    rdMux = '0;
    if (isScratch) begin
      rdMux = scratch_q[bus.adr[1:0]];
    end else begin
      case (bus.adr)
        REG_STATUS: rdMux = {5'b0, ctrl_q[CTRL_EN], underrun_q, src_vld_i};
        REG_CTRL:   rdMux = ctrl_q;
        REG_COUNT:  rdMux = count_q;
        default:    rdMux = '0;
      endcase
    end
  end

  // Next-state logic for the transfer FSM and the register file. Clears
  // are applied before pop/underrun events so a same-cycle event wins.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ack_d      = 1'b0;
    dat_d      = dat_q;
    ctrl_d     = ctrl_q;
    underrun_d = underrun_q;
    count_d    = count_q;
    scratch_d  = scratch_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (streamRd && ctrl_q[CTRL_EN]) begin
            if (src_vld_i) begin
              pop = 1'b1;
            end else begin
              state_d = ST_WAIT;
              timer_d = '0;
            end
          end else begin
            ack_d = 1'b1;
            dat_d = rdMux;
            if (bus.we) begin
              if (bus.adr == REG_CTRL) begin
                ctrl_d           = bus.datW;
                ctrl_d[CTRL_CLR] = 1'b0;
                if (bus.datW[CTRL_CLR]) begin
                  underrun_d = 1'b0;
                  count_d    = '0;
                end
              end else if (isScratch) begin
                scratch_d[bus.adr[1:0]] = bus.datW;
              end
            end
          end
        end
      end

      ST_WAIT: begin
        if (!bus.cyc) begin
          state_d = ST_IDLE;
        end else if (src_vld_i && ctrl_q[CTRL_EN]) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          ack_d      = 1'b1;
          dat_d      = UNDERRUN_FILL;
          underrun_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      ack_d   = 1'b1;
      dat_d   = src_dat_i;
      count_d = count_q + 8'd1;
    end
  end

  // State and register file update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_q     <= CTRL_INIT;
      underrun_q <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      ctrl_q     <= ctrl_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      for (int i = 0; i < 4; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  // The pop strobe is masked by reset so an aborted transfer never pops.
  assign src_rdy_o  = pop && !rst_i;
  assign bus.ack    = ack_q;
  assign bus.datR   = dat_q;
  assign ctrl_o     = ctrl_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_bus_regs.sv
// tb_spi_bus_regs
// Purpose: directed, table-driven bench for spi_bus_regs. Register accesses
//   come from a vector table; stream pops, underrun timeout, clear and
//   reset-during-wait are hand-written sequences.
module tb_spi_bus_regs;
  import spi_bus_regs_pkg::*;

  typedef struct {
    bit         we;
    logic [6:0] adr;
    logic [7:0] wdat;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] srcDat;
  logic       srcVld;
  logic       srcRdy;
  logic [7:0] ctrlO;
  logic       underrunO;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  vec_t vecs[$];

  spi_bus_regs_if #(.WIDTH(8), .ASB(6)) bus ();

  spi_bus_regs #(
    .WIDTH(8), .ASB(6), .TIMEOUT(15), .CTRL_INIT(8'h01)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .src_dat_i(srcDat), .src_vld_i(srcVld), .src_rdy_o(srcRdy),
    .ctrl_o(ctrlO), .underrun_o(underrunO)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Pop strobes are counted mid-cycle, away from the active edge
  always @(negedge clk) if (srcRdy) pops++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus transfer. riseAt>0 raises srcVld with riseDat that many cycles
  // after the hit. lat is -1 if no ack arrives within the budget.
  task automatic applyStimulus(input bit we, input logic [6:0] adr, input logic [7:0] wdat,
                               input int riseAt, input logic [7:0] riseDat,
                               output logic [7:0] rdat, output int lat);
    rdat = '0;
    lat  = -1;
    @(posedge clk); #1;
    bus.cyc  = 1'b1;
    bus.stb  = 1'b1;
    bus.we   = we;
    bus.adr  = adr;
    bus.datW = wdat;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        lat  = k;
        rdat = bus.datR;
        break;
      end
      if (k == riseAt) begin
        srcVld = 1'b1;
        srcDat = riseDat;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ackSingle_a%0h", adr), {31'b0, bus.ack}, 32'd0);
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic doRead(input string name, input logic [6:0] adr,
                        input logic [7:0] exp, input int expLat);
    logic [7:0] rd;
    int         lat;
    applyStimulus(1'b0, adr, 8'h00, -1, 8'h00, rd, lat);
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_dat"}, {24'b0, rd}, {24'b0, exp});
  endtask

  task automatic doWrite(input string name, input logic [6:0] adr, input logic [7:0] wdat);
    logic [7:0] rd;
    int         lat;
    applyStimulus(1'b1, adr, wdat, -1, 8'h00, rd, lat);
    checkOutput({name, "_lat"}, 32'(lat), 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    int         p0;
    int         ackSeen;

    rst      = 1'b1;
    bus.cyc  = 1'b0;
    bus.stb  = 1'b0;
    bus.we   = 1'b0;
    bus.adr  = '0;
    bus.datW = '0;
    srcVld   = 1'b0;
    srcDat   = '0;

    vecs.push_back('{1'b0, 7'h01, 8'h00, 1'b1, 8'h01});
    vecs.push_back('{1'b0, 7'h03, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 7'h04, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 7'h05, 8'h5A, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 7'h05, 8'h00, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 7'h03, 8'h33, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 7'h03, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 7'h40, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 7'h00, 8'h00, 1'b1, 8'h04});
    vecs.push_back('{1'b1, 7'h07, 8'hC9, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 7'h07, 8'h00, 1'b1, 8'hC9});
    vecs.push_back('{1'b0, 7'h04, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 7'h01, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 7'h01, 8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b1, 7'h01, 8'h01, 1'b0, 8'h00});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ack",      {31'b0, bus.ack},   32'd0);
    checkOutput("rst_dat",      {24'b0, bus.datR},  32'h00);
    checkOutput("rst_ctrl",     {24'b0, ctrlO},     32'h01);
    checkOutput("rst_underrun", {31'b0, underrunO}, 32'd0);
    checkOutput("rst_srcRdy",   {31'b0, srcRdy},    32'd0);

    // Register-access vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].wdat, -1, 8'h00, rd, lat);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      if (vecs[i].chk)
        checkOutput($sformatf("vec%0d_dat", i), {24'b0, rd}, {24'b0, vecs[i].exp});
    end
    checkOutput("ctrl_after_table", {24'b0, ctrlO}, 32'h01);

    // Three back-to-back pops with data present
    p0     = pops;
    srcVld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      srcDat = 8'(8'h10 + i);
      doRead($sformatf("pop%0d", i), REG_STREAM, 8'(8'h10 + i), 1);
    end
    srcVld = 1'b0;
    checkOutput("pop_pulses", 32'(pops - p0), 32'd3);
    doRead("count3", REG_COUNT, 8'h03, 1);

    // Data arrives five cycles into the wait
    p0 = pops;
    applyStimulus(1'b0, REG_STREAM, 8'h00, 5, 8'hC3, rd, lat);
    srcVld = 1'b0;
    checkOutput("late_lat", 32'(lat), 32'd6);
    checkOutput("late_dat", {24'b0, rd}, 32'hC3);
    checkOutput("late_pulses", 32'(pops - p0), 32'd1);
    checkOutput("late_underrun", {31'b0, underrunO}, 32'd0);

    // No data at all: timeout, fill byte, sticky underrun, no pop
    p0 = pops;
    applyStimulus(1'b0, REG_STREAM, 8'h00, -1, 8'h00, rd, lat);
    checkOutput("uflow_lat", 32'(lat), 32'd16);
    checkOutput("uflow_dat", {24'b0, rd}, 32'hFF);
    checkOutput("uflow_pulses", 32'(pops - p0), 32'd0);
    checkOutput("uflow_flag", {31'b0, underrunO}, 32'd1);
    doRead("uflow_status", REG_STATUS, 8'h06, 1);
    doRead("uflow_count", REG_COUNT, 8'h04, 1);

    // Clear: zeroes underrun/count, bit1 self-clears, stream disabled
    doWrite("clr", REG_CTRL, 8'h02);
    checkOutput("clr_underrun", {31'b0, underrunO}, 32'd0);
    checkOutput("clr_ctrlO", {24'b0, ctrlO}, 32'h00);
    doRead("clr_ctrl", REG_CTRL, 8'h00, 1);
    doRead("clr_count", REG_COUNT, 8'h00, 1);
    doRead("clr_status", REG_STATUS, 8'h00, 1);
    p0     = pops;
    srcVld = 1'b1;
    srcDat = 8'h77;
    doRead("dis_stream", REG_STREAM, 8'h00, 1);
    checkOutput("dis_pulses", 32'(pops - p0), 32'd0);
    srcVld = 1'b0;

    // Reset while a stream read is waiting: no ack, no pop, ctrl restored
    doWrite("en_fd", REG_CTRL, 8'hFD);
    checkOutput("ctrl_fd", {24'b0, ctrlO}, 32'hFD);
    p0 = pops;
    @(posedge clk); #1;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = REG_STREAM;
    ackSeen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.ack) ackSeen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ack) ackSeen++;
    end
    checkOutput("rstwait_ack", 32'(ackSeen), 32'd0);
    checkOutput("rstwait_pulses", 32'(pops - p0), 32'd0);
    checkOutput("rstwait_ctrl", {24'b0, ctrlO}, 32'h01);
    doRead("rstwait_idle", REG_CTRL, 8'h01, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
